// File: rtl/reg_share_arbiter_pkg.sv
// reg_share_arbiter_pkg
// Shared constants for the two-requester register-sharing arbiter:
// FSM state encoding, default data width and default grant-hold limit.
// No ports; imported by share_reg and reg_share_arbiter.

package reg_share_arbiter_pkg;

    // Arbiter FSM states; the encoding is fixed so it can be probed directly.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        OWN0 = 2'b01,
        OWN1 = 2'b10
    } arb_state_e;

    localparam int ARB_W_DEFAULT   = 2;
    localparam int ARB_TMO_DEFAULT = 16;
    localparam int ARB_CNT_W       = 8;

    // True when the state represents an active grant to either requester.
    function automatic logic is_owned(input arb_state_e s);
        return (s == OWN0) || (s == OWN1);
    endfunction

endpackage

// File: rtl/reg_share_arbiter_share_reg.sv
// share_reg
// W-bit shared storage register with asynchronous active-low clear and a
// load enable. The arbiter owns both the enable and the data selection.
// Ports:
//   clk  - clock
//   clr  - asynchronous active-low clear (q -> 0)
//   en   - load enable, q takes d on the rising edge when high
//   d    - load data
//   q    - register contents

module share_reg
    import reg_share_arbiter_pkg::*;
#(
    parameter int W = ARB_W_DEFAULT
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] q_r;

    // Storage element: clear immediately on clr, load on enable, else hold.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            q_r <= '0;
        end else if (en) begin
            q_r <= d;
        end else begin
            q_r <= q_r;
        end
    end

    assign q = q_r;

endmodule

// File: rtl/reg_share_arbiter.sv
// reg_share_arbiter
// Round-robin arbiter granting one of two requesters exclusive write access
// to a single shared W-bit register. Every hand-over passes through IDLE.
// Optional feature macro: ARB_TIMEOUT_EN -- adds a grant-hold counter that
// forces a release after TMO_CYCLES cycles, pulses tmo, and locks the
// timed-out requester out until it drops its request for a cycle.
// Ports:
//   clk          - clock
//   clr          - asynchronous active-low reset
//   req0, req1   - level access requests
//   we0, we1     - write enables, only honoured for the granted requester
//   d0, d1       - write data
//   gnt0, gnt1   - registered grants (one-hot or zero)
//   q            - shared register contents
//   busy         - high while either grant is high
//   tmo          - one-cycle timeout pulse (ARB_TIMEOUT_EN only)

module reg_share_arbiter
    import reg_share_arbiter_pkg::*;
#(
    parameter int W          = ARB_W_DEFAULT,
    parameter int TMO_CYCLES = ARB_TMO_DEFAULT
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         req0,
    input  logic         req1,
    input  logic         we0,
    input  logic         we1,
    input  logic [W-1:0] d0,
    input  logic [W-1:0] d1,
    output logic         gnt0,
    output logic         gnt1,
    output logic [W-1:0] q,
    output logic         busy
`ifdef ARB_TIMEOUT_EN
    ,
    output logic         tmo
`endif
);

    // Reject an out-of-range hold limit at elaboration time.
    if ((TMO_CYCLES < 2) || (TMO_CYCLES > 255)) begin : g_bad_tmo
        $error("reg_share_arbiter: TMO_CYCLES must be within 2..255");
    end

    arb_state_e   state_r;
    arb_state_e   state_next_s;
    logic         ptr_r;         // 1'b0 favours requester 0, 1'b1 favours requester 1
    logic         ptr_next_s;
    logic         arm_r;         // low for the first edge after reset: no stale req is granted
    logic         gnt0_r;
    logic         gnt1_r;
    logic         busy_r;
    logic         elig0_s;
    logic         elig1_s;
    logic         wr_en_s;
    logic [W-1:0] wr_data_s;

`ifdef ARB_TIMEOUT_EN
    localparam logic [ARB_CNT_W-1:0] TMO_LAST = ARB_CNT_W'(TMO_CYCLES - 1);

    logic [ARB_CNT_W-1:0] cnt_r;
    logic                 tmo_r;
    logic                 tmo_next_s;
    logic                 lock0_r;
    logic                 lock1_r;
    logic                 lock0_next_s;
    logic                 lock1_next_s;
    logic                 expire_s;

    assign expire_s = (cnt_r == TMO_LAST);
    assign elig0_s  = req0 & ~lock0_r;
    assign elig1_s  = req1 & ~lock1_r;
`else
    assign elig0_s  = req0;
    assign elig1_s  = req1;
`endif

    // Next-state, pointer, write-enable and lockout decisions.
    always_comb begin
        state_next_s = state_r;
        ptr_next_s   = ptr_r;
        wr_en_s      = 1'b0;
`ifdef ARB_TIMEOUT_EN
        tmo_next_s   = 1'b0;
        // A lockout lasts until its requester has been seen low once.
        lock0_next_s = lock0_r & req0;
        lock1_next_s = lock1_r & req1;
`endif
        case (state_r)
            IDLE: begin
                if (!arm_r) begin
                    state_next_s = IDLE;
                end else if (elig0_s && elig1_s) begin
                    state_next_s = ptr_r ? OWN1 : OWN0;
                end else if (elig0_s) begin
                    state_next_s = OWN0;
                end else if (elig1_s) begin
                    state_next_s = OWN1;
                end else begin
                    state_next_s = IDLE;
                end
            end
            OWN0: begin
                if (!req0) begin
                    // Release cycle: any write request here is dropped.
                    state_next_s = IDLE;
                    ptr_next_s   = 1'b1;
                end else begin
                    wr_en_s = we0;
`ifdef ARB_TIMEOUT_EN
                    if (expire_s) begin
                        state_next_s = IDLE;
                        ptr_next_s   = 1'b1;
                        tmo_next_s   = 1'b1;
                        lock0_next_s = 1'b1;
                    end else begin
                        state_next_s = OWN0;
                    end
`else
                    state_next_s = OWN0;
`endif
                end
            end
            OWN1: begin
                if (!req1) begin
                    state_next_s = IDLE;
                    ptr_next_s   = 1'b0;
                end else begin
                    wr_en_s = we1;
`ifdef ARB_TIMEOUT_EN
                    if (expire_s) begin
                        state_next_s = IDLE;
                        ptr_next_s   = 1'b0;
                        tmo_next_s   = 1'b1;
                        lock1_next_s = 1'b1;
                    end else begin
                        state_next_s = OWN1;
                    end
`else
                    state_next_s = OWN1;
`endif
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Data-select mux into the shared register: the owner's data only.
    always_comb begin
        if (state_r == OWN1) begin
            wr_data_s = d1;
        end else begin
            wr_data_s = d0;
        end
    end

    // FSM state, round-robin pointer, arm flag and registered grant outputs.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_r <= IDLE;
            ptr_r   <= 1'b0;
            arm_r   <= 1'b0;
            gnt0_r  <= 1'b0;
            gnt1_r  <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            ptr_r   <= ptr_next_s;
            arm_r   <= 1'b1;
            gnt0_r  <= (state_next_s == OWN0);
            gnt1_r  <= (state_next_s == OWN1);
            busy_r  <= is_owned(state_next_s);
        end
    end

`ifdef ARB_TIMEOUT_EN
    // Hold counter (zero on entry, +1 per owned cycle), timeout pulse, lockouts.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            cnt_r   <= '0;
            tmo_r   <= 1'b0;
            lock0_r <= 1'b0;
            lock1_r <= 1'b0;
        end else begin
            if (state_r == IDLE) begin
                cnt_r <= '0;
            end else begin
                cnt_r <= cnt_r + ARB_CNT_W'(1);
            end
            tmo_r   <= tmo_next_s;
            lock0_r <= lock0_next_s;
            lock1_r <= lock1_next_s;
        end
    end

    assign tmo = tmo_r;
`endif

    share_reg #(
        .W (W)
    ) u_share_reg (
        .clk (clk),
        .clr (clr),
        .en  (wr_en_s),
        .d   (wr_data_s),
        .q   (q)
    );

    assign gnt0 = gnt0_r;
    assign gnt1 = gnt1_r;
    assign busy = busy_r;

endmodule

// File: doc/reg_share_arbiter.md
REG_SHARE_ARBITER -- requirements
Module: reg_share_arbiter

Interface
REQ-001 Parameter W, default 2, data width of the shared register.
REQ-002 Parameter TMO_CYCLES, default 16, grant-hold limit in cycles; legal range 2..255; used only with ARB_TIMEOUT_EN.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 clr  input  1  reset, asynchronous, active-low.
REQ-005 req0, req1  input  1 each  requester access request, level, held for the whole transaction.
REQ-006 we0, we1  input  1 each  requester write enable, honoured only while that requester is granted.
REQ-007 d0, d1  input  W each  requester write data.
REQ-008 gnt0, gnt1  output  1 each  registered grant, one-hot or zero.
REQ-009 q  output  W  shared register contents.
REQ-010 busy  output  1  high whenever either grant is high.
REQ-011 tmo  output  1  one-cycle timeout pulse; present only with ARB_TIMEOUT_EN.

Function
REQ-012 The FSM SHALL have exactly the states IDLE, OWN0 and OWN1.
REQ-013 In IDLE with exactly one req high, the FSM SHALL move to that requester's OWN state on the next edge.
REQ-014 In IDLE with both req high, the FSM SHALL grant the requester not served last (round-robin pointer); after reset the pointer SHALL favour requester 0.
REQ-015 gnt0/gnt1 SHALL be decoded from state only, so grant latency is exactly one cycle from a sampled req.
REQ-016 In OWNn with reqn high and wen high, q SHALL load dn on that edge; with wen low, q SHALL hold.
REQ-017 The non-granted requester's we and d SHALL never affect q.
REQ-018 In OWNn with reqn low, the FSM SHALL return to IDLE and update the pointer to favour the other requester; q SHALL hold.
REQ-019 A requester dropping and re-raising req in consecutive cycles SHALL see gnt low for at least one cycle; back-to-back grants SHALL always pass through IDLE.
REQ-020 A req rising in the same cycle as the owner releases SHALL be arbitrated from IDLE on the following edge.
REQ-021 Write data on the release cycle (reqn low) SHALL be ignored even if wen is high.

Reset
REQ-022 While clr is low: state IDLE, gnt0=gnt1=0, busy=0, tmo=0, q=0, pointer favours requester 0, timeout counter 0, all immediately and independent of clk.
REQ-023 Reset asserted mid-transaction SHALL abort the grant with no write on that cycle; the first grant after clr rises SHALL need a fresh sampled req.

Configuration
REQ-024 With macro ARB_TIMEOUT_EN defined, a hold counter SHALL clear on entry to OWN0/OWN1, increment each cycle in OWN0/OWN1, and on reaching TMO_CYCLES force IDLE, pulse tmo for one cycle, and point priority at the other requester.
REQ-025 A forced release SHALL block the timed-out requester from being regranted until it drops req for at least one cycle.
REQ-026 Without ARB_TIMEOUT_EN, the tmo port, counter and lockout logic SHALL be absent, and a grant SHALL persist until release.

Structure
REQ-027 The state encodings (IDLE=2'b00, OWN0=2'b01, OWN1=2'b10) and the default W and TMO_CYCLES values SHALL reside in the shared arbiter constants package or include.
REQ-028 The shared register SHALL be one sub-module, share_reg (W-bit, async active-low clear, load enable), instantiated once; the arbiter drives its enable and its data-select mux.

Verification
REQ-029 Reset: hold clr=0 with req0=1 and we0=1 -> gnt0=gnt1=0 and q=0; release clr -> gnt0=1 on the second edge.
REQ-030 Single write: req0=1, then we0=1 and d0=2'b10 one cycle after gnt0 -> q=2'b10 on the next edge; drop req0 -> gnt0=0 and q holds 2'b10.
REQ-031 Contention: req0=req1=1 from IDLE after reset -> gnt0 first; on release -> one IDLE cycle, then gnt1; repeat -> alternates 0,1,0,1.
REQ-032 Isolation: gnt1 held, we0=1 with d0=2'b11 and we1=0 -> q unchanged.
REQ-033 Timeout (ARB_TIMEOUT_EN, TMO_CYCLES=4): req0 held with req1=1 -> gnt0 for 4 cycles, tmo single pulse, then gnt1; req0 not regranted until it toggles low.
REQ-034 Mid-operation reset: clr pulsed low for under one clock period while gnt1=1 and we1=1 -> immediate IDLE, q=0, no write.
